jt9346_ctrl: RTL

Serial EEPROM master that sequences the jt9346 93C46-style device model, or a real 93C46 on the board. It turns single parallel commands (READ, WRITE, ERASE, EWEN, EWDS, ERAL, WRAL) into the Microwire frame on scs/sclk/sdi. It captures read data from sdo, and for program commands it polls the device's ready/busy status. It sits between a core's NVRAM load/save logic and the EEPROM pins.

---
 rtl/jt9346_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/jt9346_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jt9346_ctrl
// Brief    : Microwire master turning parallel commands into 93C46-style
//            frames, with read capture and ready/busy polling.
// Revision : 1.0
// ============================================================================
module jt9346_ctrl #(
    parameter int AW   = 6,
    parameter int DW   = 16,
    parameter int DIV  = 2,
    parameter int TOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_din,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic          scs,
    output logic          sclk,
    output logic          sdi,
    input  logic          sdo
);

    localparam int c_FL = 3 + AW + DW;
    localparam int c_CW = $clog2(2 * DIV + 1);
    localparam int c_BW = $clog2(c_FL + 1);
    localparam int c_PW = $clog2(TOUT + 1);

    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_HALF    = c_CW'(DIV);
    localparam logic [c_CW-1:0] c_PER_M1  = c_CW'(2 * DIV - 1);
    localparam logic [c_BW-1:0] c_HDR_M1  = c_BW'(3 + AW - 1);
    localparam logic [c_BW-1:0] c_FULL_M1 = c_BW'(c_FL - 1);
    localparam logic [c_BW-1:0] c_DW_M1   = c_BW'(DW - 1);
    localparam logic [c_PW-1:0] c_TOUT_M1 = c_PW'(TOUT - 1);

    localparam logic [2:0] c_OP_READ  = 3'd0;
    localparam logic [2:0] c_OP_WRITE = 3'd1;
    localparam logic [2:0] c_OP_ERASE = 3'd2;
    localparam logic [2:0] c_OP_EWEN  = 3'd3;
    localparam logic [2:0] c_OP_EWDS  = 3'd4;
    localparam logic [2:0] c_OP_ERAL  = 3'd5;
    localparam logic [2:0] c_OP_WRAL  = 3'd6;
    localparam logic [2:0] c_OP_ILL   = 3'd7;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SHIFT = 3'd1;
    localparam logic [2:0] c_ST_RDIN  = 3'd2;
    localparam logic [2:0] c_ST_GAP   = 3'd3;
    localparam logic [2:0] c_ST_POLL  = 3'd4;
    localparam logic [2:0] c_ST_END   = 3'd5;

    logic [2:0]      r_state, w_state;
    logic [c_CW-1:0] r_cnt, w_cnt;
    logic [c_BW-1:0] r_bit, w_bit;
    logic [c_BW-1:0] r_last_bit, w_last_bit;
    logic [c_PW-1:0] r_pcnt, w_pcnt;
    logic [2:0]      r_op, w_op;
    logic [c_FL-1:0] r_sh, w_sh;
    logic [DW-1:0]   r_rsh, w_rsh;
    logic            r_err, w_err;
    logic [DW-1:0]   r_rd_data;

    logic [1:0]      w_opc;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_has_data;
    logic [c_FL-1:0] w_frame;
    logic            w_per_end;
    logic            w_ld_rd;

    // Frame image for the incoming command: start bit, opcode, address, data.
    always_comb begin
        w_opc  = 2'b00;
        w_addr = cmd_addr;
        w_data = '0;
        case (cmd_op)
            c_OP_READ:  w_opc = 2'b10;
            c_OP_WRITE: begin
                w_opc  = 2'b01;
                w_data = cmd_din;
            end
            c_OP_ERASE: w_opc = 2'b11;
            c_OP_EWEN: begin
                w_addr = '0;
                w_addr[AW-1 -: 2] = 2'b11;
            end
            c_OP_EWDS:  w_addr = '0;
            c_OP_ERAL: begin
                w_addr = '0;
                w_addr[AW-1 -: 2] = 2'b10;
            end
            c_OP_WRAL: begin
                w_addr = '0;
                w_addr[AW-1 -: 2] = 2'b01;
                w_data = cmd_din;
            end
            default: ;
        endcase
    end

    assign w_has_data = (cmd_op == c_OP_WRITE) || (cmd_op == c_OP_WRAL);
    assign w_frame    = {1'b1, w_opc, w_addr, w_data};
    assign w_per_end  = (r_cnt == c_PER_M1);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit      = r_bit;
        w_last_bit = r_last_bit;
        w_pcnt     = r_pcnt;
        w_op       = r_op;
        w_sh       = r_sh;
        w_rsh      = r_rsh;
        w_err      = r_err;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    w_op  = cmd_op;
                    w_cnt = '0;
                    w_bit = '0;
                    w_err = 1'b0;
                    // Illegal op lands directly on the final END cycle: no bus activity.
                    if (cmd_op == c_OP_ILL) begin
                        w_state = c_ST_END;
                        w_cnt   = c_HALF_M1;
                        w_err   = 1'b1;
                    end else begin
                        w_state    = c_ST_SHIFT;
                        w_sh       = w_frame;
                        w_last_bit = w_has_data ? c_FULL_M1 : c_HDR_M1;
                    end
                end
            end
            c_ST_SHIFT: begin
                if (w_per_end) begin
                    w_cnt = '0;
                    w_sh  = {r_sh[c_FL-2:0], 1'b0};
                    w_bit = r_bit + 1'b1;
                    if (r_bit == r_last_bit) begin
                        w_bit = '0;
                        if (r_op == c_OP_READ)
                            w_state = c_ST_RDIN;
                        else if ((r_op == c_OP_EWEN) || (r_op == c_OP_EWDS))
                            w_state = c_ST_END;
                        else
                            w_state = c_ST_GAP;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_RDIN: begin
                if (w_per_end) begin
                    w_cnt = '0;
                    w_rsh = {r_rsh[DW-2:0], sdo};
                    w_bit = r_bit + 1'b1;
                    if (r_bit == c_DW_M1) begin
                        w_bit   = '0;
                        w_state = c_ST_END;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt   = '0;
                    w_pcnt  = '0;
                    w_state = c_ST_POLL;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_POLL: begin
                // The first poll sample still reflects the bus before CS re-rose.
                if ((r_pcnt != '0) && sdo) begin
                    w_cnt   = '0;
                    w_state = c_ST_END;
                end else if (r_pcnt == c_TOUT_M1) begin
                    w_cnt   = '0;
                    w_err   = 1'b1;
                    w_state = c_ST_END;
                end else begin
                    w_pcnt = r_pcnt + 1'b1;
                end
            end
            c_ST_END: begin
                if (r_cnt == c_HALF_M1)
                    w_state = c_ST_IDLE;
                else
                    w_cnt = r_cnt + 1'b1;
            end
            default: w_state = c_ST_IDLE;
        endcase
    end

    // Read result becomes visible exactly in the cycle done pulses.
    assign w_ld_rd = (w_state == c_ST_END) && (w_cnt == c_HALF_M1) && (w_op == c_OP_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_last_bit <= '0;
            r_pcnt     <= '0;
            r_op       <= c_OP_READ;
            r_sh       <= '0;
            r_rsh      <= '0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_last_bit <= w_last_bit;
            r_pcnt     <= w_pcnt;
            r_op       <= w_op;
            r_sh       <= w_sh;
            r_rsh      <= w_rsh;
            r_err      <= w_err;
            if (w_ld_rd)
                r_rd_data <= w_rsh;
        end
    end

    assign cmd_ready = (r_state == c_ST_IDLE);
    assign done      = (r_state == c_ST_END) && (r_cnt == c_HALF_M1);
    assign err       = done && r_err;
    assign rd_data   = r_rd_data;
    assign scs       = (r_state == c_ST_SHIFT) || (r_state == c_ST_RDIN) || (r_state == c_ST_POLL);
    assign sclk      = ((r_state == c_ST_SHIFT) || (r_state == c_ST_RDIN)) && (r_cnt >= c_HALF);
    assign sdi       = (r_state == c_ST_SHIFT) && r_sh[c_FL-1];

endmodule
`default_nettype wire
